greedy_snake_dpb_w: RTL

Channel-A writer for the snake body list held in the Gowin_DPB, the counterpart of the channel-B list reader/renderer.
- Owns the circular body list: initialises it, and on each move tick writes the new head position.
- Grows the list by shifting entries when the fruit is eaten.
- Publishes list_length/list_head_addr and then kicks the reader to rebuild the map.
- Halts when the reader reports game over.

---
 rtl/greedy_snake_dpb_w_pkg.sv | 41 ++++
 rtl/greedy_snake_dpb_w_next_pos.sv | 32 +++
 rtl/greedy_snake_dpb_w.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/greedy_snake_dpb_w_pkg.sv
// Shared definitions for the snake body-list writer and its channel-B reader.
package greedy_snake_dpb_w_pkg;

  // Writer FSM encoding
  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_WAIT     = 3'd1;
  localparam logic [2:0] ST_CALC     = 3'd2;
  localparam logic [2:0] ST_SHIFT_RD = 3'd3;
  localparam logic [2:0] ST_SHIFT_WR = 3'd4;
  localparam logic [2:0] ST_WR_HEAD  = 3'd5;
  localparam logic [2:0] ST_KICK     = 3'd6;
  localparam logic [2:0] ST_HALT     = 3'd7;

  // Sub-phases of the reader handshake inside ST_KICK
  localparam logic [1:0] KICK_PULSE     = 2'd0;
  localparam logic [1:0] KICK_WAIT_RISE = 2'd1;
  localparam logic [1:0] KICK_WAIT_FALL = 2'd2;

  // Move directions
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // List layout defaults shared with the reader
  localparam logic [10:0] DEF_DATA_BEGIN_ADDRESS = 11'd4;
  localparam logic [10:0] DEF_ADDRESS_STEP_N     = 11'd4;

  function automatic logic [3:0] pos_x(input logic [7:0] pos);
    return pos[7:4];
  endfunction

  function automatic logic [3:0] pos_y(input logic [7:0] pos);
    return pos[3:0];
  endfunction

  function automatic logic [7:0] pos_pack(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/greedy_snake_dpb_w_next_pos.sv
// Combinational head-move step: filters reversals and advances the head by one cell.
module snake_next_pos
  import greedy_snake_dpb_w_pkg::*;
(
  input  logic [1:0] cur_dir,
  input  logic [1:0] req_dir,
  input  logic [7:0] head_pos,
  output logic [1:0] eff_dir,
  output logic [7:0] new_pos
);

  logic       reverse;
  logic [3:0] nx;
  logic [3:0] ny;

  // Keep the current heading on a 180-degree request; nibbles wrap mod 16
  always_comb begin
    // Reverse pairs share bit 1 and differ in bit 0 (0<->1, 2<->3)
    reverse = (req_dir[1] == cur_dir[1]) && (req_dir[0] != cur_dir[0]);
    eff_dir = reverse ? cur_dir : req_dir;
    nx      = pos_x(head_pos);
    ny      = pos_y(head_pos);
    case (eff_dir)
      DIR_UP:   ny = pos_y(head_pos) - 4'd1;
      DIR_DOWN: ny = pos_y(head_pos) + 4'd1;
      DIR_LEFT: nx = pos_x(head_pos) - 4'd1;
      default:  nx = pos_x(head_pos) + 4'd1;
    endcase
    new_pos = pos_pack(nx, ny);
  end

endmodule

// File: rtl/greedy_snake_dpb_w.sv
// Channel-A writer for the circular snake body list held in the dual-port block RAM.
module greedy_snake_dpb_w
  import greedy_snake_dpb_w_pkg::*;
#(
  parameter logic [10:0] ADDRESS_STEP_N     = DEF_ADDRESS_STEP_N,
  parameter logic [10:0] DATA_BEGIN_ADDRESS = DEF_DATA_BEGIN_ADDRESS,
  parameter logic [10:0] MAX_LENGTH         = 11'd64,
  parameter logic [10:0] INIT_LENGTH        = 11'd3,
  parameter logic [7:0]  INIT_HEAD_POS      = 8'h53,
  // Must be at least 1
  parameter logic [3:0]  RD_LATENCY         = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [1:0]  dir,
  input  logic [7:0]  point_pos,
  input  logic        rd_busy,
  input  logic        game_over_flag,
  output logic        rd_en,
  output logic        busy,
  output logic        halted,
  output logic [10:0] list_length,
  output logic [10:0] list_head_addr,
  output logic        i_a_clk_en,
  output logic        i_a_data_en,
  output logic        i_a_wr_en,
  output logic [7:0]  i_a_data,
  output logic [10:0] i_a_address,
  input  logic [7:0]  o_a_data
);

  logic [2:0]  state;
  logic [1:0]  kick_ph;
  logic [10:0] init_idx;
  logic [1:0]  cur_dir;
  logic [7:0]  head_pos;
  logic [7:0]  new_pos_q;
  logic        grow_q;
  logic [10:0] head_slot;
  logic [10:0] target_slot;
  logic [10:0] shift_s;
  logic [3:0]  lat_cnt;
  logic [7:0]  shift_data;

  logic [1:0]  eff_dir;
  logic [7:0]  new_pos;
  logic        grow;
  logic [10:0] last_slot;
  logic [10:0] init_off;
  logic [7:0]  init_pos;

  function automatic logic [10:0] slot_addr(input logic [10:0] k);
    return DATA_BEGIN_ADDRESS + k * ADDRESS_STEP_N;
  endfunction

  assign i_a_clk_en  = 1'b1;
  assign i_a_data_en = 1'b1;
  assign busy        = (state != ST_WAIT);
  assign halted      = (state == ST_HALT);

  snake_next_pos u_next_pos (
    .cur_dir  (cur_dir),
    .req_dir  (dir),
    .head_pos (head_pos),
    .eff_dir  (eff_dir),
    .new_pos  (new_pos)
  );

  // Growth decision and the initial body position for the slot being written
  always_comb begin
    last_slot = list_length - 11'd1;
    grow      = (new_pos == point_pos) && (list_length < MAX_LENGTH);
    // Slot i sits (INIT_LENGTH-1-i) cells left of the initial head
    init_off  = INIT_LENGTH - 11'd1 - init_idx;
    init_pos  = pos_pack(pos_x(INIT_HEAD_POS) - init_off[3:0], pos_y(INIT_HEAD_POS));
  end

  // Main sequencer; channel-A outputs are registered, so a write issued here lands next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT;
      kick_ph        <= KICK_PULSE;
      init_idx       <= 11'd0;
      cur_dir        <= DIR_RIGHT;
      head_pos       <= 8'd0;
      new_pos_q      <= 8'd0;
      grow_q         <= 1'b0;
      head_slot      <= 11'd0;
      target_slot    <= 11'd0;
      shift_s        <= 11'd0;
      lat_cnt        <= 4'd0;
      shift_data     <= 8'd0;
      rd_en          <= 1'b0;
      list_length    <= 11'd0;
      list_head_addr <= DATA_BEGIN_ADDRESS;
      i_a_wr_en      <= 1'b0;
      i_a_data       <= 8'd0;
      i_a_address    <= 11'd0;
    end else begin
      i_a_wr_en <= 1'b0;
      rd_en     <= 1'b0;
      case (state)
        ST_INIT: begin
          i_a_wr_en   <= 1'b1;
          i_a_address <= slot_addr(init_idx);
          i_a_data    <= init_pos;
          init_idx    <= init_idx + 11'd1;
          if (init_idx == INIT_LENGTH - 11'd1) begin
            list_length    <= INIT_LENGTH;
            head_slot      <= INIT_LENGTH - 11'd1;
            list_head_addr <= slot_addr(INIT_LENGTH - 11'd1);
            head_pos       <= INIT_HEAD_POS;
            kick_ph        <= KICK_PULSE;
            state          <= ST_KICK;
          end
        end
        ST_WAIT: begin
          if (step) state <= ST_CALC;
        end
        ST_CALC: begin
          cur_dir   <= eff_dir;
          new_pos_q <= new_pos;
          grow_q    <= grow;
          if (!grow) begin
            // Plain move overwrites the tail, which is the slot after the head
            target_slot <= (head_slot == last_slot) ? 11'd0 : head_slot + 11'd1;
            state       <= ST_WR_HEAD;
          end else if (head_slot == last_slot) begin
            target_slot <= list_length;
            state       <= ST_WR_HEAD;
          end else begin
            // Open a gap after the head by moving slots head+1..L-1 up by one
            shift_s <= last_slot;
            lat_cnt <= 4'd0;
            state   <= ST_SHIFT_RD;
          end
        end
        ST_SHIFT_RD: begin
          if (lat_cnt == 4'd0) begin
            i_a_address <= slot_addr(shift_s);
            lat_cnt     <= 4'd1;
          end else if (lat_cnt == RD_LATENCY) begin
            shift_data <= o_a_data;
            lat_cnt    <= 4'd0;
            state      <= ST_SHIFT_WR;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        ST_SHIFT_WR: begin
          i_a_wr_en   <= 1'b1;
          i_a_address <= slot_addr(shift_s + 11'd1);
          i_a_data    <= shift_data;
          if (shift_s == head_slot + 11'd1) begin
            target_slot <= head_slot + 11'd1;
            state       <= ST_WR_HEAD;
          end else begin
            shift_s <= shift_s - 11'd1;
            state   <= ST_SHIFT_RD;
          end
        end
        ST_WR_HEAD: begin
          i_a_wr_en      <= 1'b1;
          i_a_address    <= slot_addr(target_slot);
          i_a_data       <= new_pos_q;
          head_pos       <= new_pos_q;
          head_slot      <= target_slot;
          list_head_addr <= slot_addr(target_slot);
          if (grow_q) list_length <= list_length + 11'd1;
          kick_ph        <= KICK_PULSE;
          state          <= ST_KICK;
        end
        ST_KICK: begin
          case (kick_ph)
            KICK_PULSE: begin
              rd_en   <= 1'b1;
              kick_ph <= KICK_WAIT_RISE;
            end
            KICK_WAIT_RISE: begin
              if (rd_busy) kick_ph <= KICK_WAIT_FALL;
            end
            default: begin
              if (!rd_busy) state <= game_over_flag ? ST_HALT : ST_WAIT;
            end
          endcase
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule
